spi_master_core: RTL and testbench

Synthesizable SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that starts frames and shifts bytes out on mosi while sampling miso. It replaces the behavioural SPI master model as the frame initiator, so the existing SPI slave receiver has a real RTL counterpart. User side is a byte-wide valid/ready stream with a frame-end marker. Received bytes come back as single-cycle pulses.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_clk_div.sv | 30 +++
 rtl/spi_master_core.sv | 147 ++++++++++++++
 tb/tb_spi_master_core.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master core.
package spi_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        NEXT,
        HOLD,
        GAP
    } spi_state_t;

    // SPI mode 0: clock idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Default transfer word width
    localparam int unsigned DATA_W_DEF = 8;

    // Half-period counter width, sized for the largest legal divider (255)
    localparam int unsigned HALF_CNT_W = $clog2(255);

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [HALF_CNT_W-1:0] LAST_CNT = HALF_CNT_W'(CLK_DIV - 1);

    logic [HALF_CNT_W-1:0] cnt;

    // Free-running count while enabled; wraps on tick, clears when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || (cnt == LAST_CNT)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + HALF_CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST_CNT);

endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master: byte stream in, serial frame out, sampled bytes back as pulses.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_ss,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    spi_state_t        state, state_n;
    logic              tick;
    logic              div_en;
    logic              hs;
    logic              rise;
    logic              fall;
    logic              last_fall;
    logic              ready_n;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              last_q;
    logic [BIT_W-1:0]  bit_cnt;

    assign div_en = (state == SETUP) || (state == SHIFT) ||
                    (state == HOLD)  || (state == GAP);
    assign busy   = (state != IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .tick (tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and per-cycle datapath strobes
    always_comb begin
        state_n   = state;
        hs        = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        last_fall = 1'b0;
        case (state)
            IDLE, NEXT: begin
                if (tx_valid && tx_ready) begin
                    hs      = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_n = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!spi_clk) begin
                        rise = 1'b1;
                    end else begin
                        fall = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            last_fall = 1'b1;
                            state_n   = last_q ? HOLD : NEXT;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) state_n = GAP;
            end
            GAP: begin
                if (tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Ready is held off for the cycle rx_valid pulses so the two never coincide
        ready_n = (state_n == IDLE) || ((state_n == NEXT) && !last_fall);
    end

    // Serial datapath, handshake outputs and slave select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            spi_clk  <= SPI_CPOL;
            spi_ss   <= 1'b1;
            mosi     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            last_q   <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            tx_ready <= ready_n;
            rx_valid <= last_fall;
            if (hs) begin
                tx_sr   <= tx_data;
                last_q  <= tx_last;
                mosi    <= tx_data[DATA_W-1];
                spi_ss  <= 1'b0;
                bit_cnt <= '0;
            end
            if (rise) begin
                spi_clk <= 1'b1;
                rx_sr   <= {rx_sr[DATA_W-2:0], miso};
            end
            if (fall) begin
                spi_clk <= 1'b0;
                bit_cnt <= bit_cnt + BIT_W'(1);
                if (!last_fall) begin
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    mosi  <= tx_sr[DATA_W-2];
                end
            end
            if (last_fall) begin
                rx_data <= rx_sr;
            end
            if ((state == HOLD) && tick) begin
                spi_ss <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed self-checking bench for spi_master_core (CLK_DIV=2 and CLK_DIV=1 instances).
module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    // CLK_DIV=2 instance
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_clk;
    logic       spi_ss;
    logic       mosi;
    logic       miso;
    logic       loop = 1'b1;
    logic       miso_fix = 1'b0;
    assign miso = loop ? mosi : miso_fix;

    // CLK_DIV=1 instance, always in loopback
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2;
    logic [7:0] tx_data2 = 8'h00;
    logic       tx_last2 = 1'b0;
    logic       rx_valid2;
    logic [7:0] rx_data2;
    logic       busy2;
    logic       spi_clk2;
    logic       spi_ss2;
    logic       mosi2;

    spi_master_core #(.CLK_DIV(2), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .spi_clk(spi_clk), .spi_ss(spi_ss), .mosi(mosi), .miso(miso)
    );

    spi_master_core #(.CLK_DIV(1), .DATA_W(8)) dut2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx_data(tx_data2), .tx_last(tx_last2), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .busy(busy2), .spi_clk(spi_clk2), .spi_ss(spi_ss2), .mosi(mosi2), .miso(mosi2)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Bus observers for instance 1 (sampled on the falling clk edge)
    int         cyc = 0;
    int         rises = 0;
    int         ss_run = 0;
    int         last_ss_run = 0;
    int         ss_rises = 0;
    int         rxv_cyc = 0;
    int         busy_fall_cyc = 0;
    int         overlap = 0;
    logic       sclk_prev = 1'b0;
    logic       ss_prev = 1'b1;
    logic       busy_prev = 1'b0;
    logic [7:0] slave_sr = 8'h00;
    int         slave_bits = 0;
    logic [7:0] rxq[$];
    logic [7:0] slave_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            ss_run = 0; slave_bits = 0; sclk_prev = 1'b0; ss_prev = 1'b1; busy_prev = 1'b0;
        end else begin
            if (spi_clk && !sclk_prev) begin
                rises++;
                slave_sr = {slave_sr[6:0], mosi};
                slave_bits++;
                if (slave_bits == 8) begin
                    slave_q.push_back(slave_sr);
                    slave_bits = 0;
                end
            end
            if (!spi_ss) begin
                ss_run++;
            end else begin
                if (!ss_prev) begin
                    last_ss_run = ss_run;
                    ss_rises++;
                end
                ss_run = 0;
                slave_bits = 0;
            end
            if (rx_valid) begin
                rxq.push_back(rx_data);
                rxv_cyc = cyc;
            end
            if (busy_prev && !busy) busy_fall_cyc = cyc;
            if (rx_valid && tx_ready) overlap++;
            sclk_prev = spi_clk;
            ss_prev   = spi_ss;
            busy_prev = busy;
        end
    end

    // Bus observers for instance 2
    int         rises2 = 0;
    int         last_rise_cyc2 = 0;
    int         rise_gap2 = 0;
    int         ss_run2 = 0;
    int         last_ss_run2 = 0;
    logic       sclk_prev2 = 1'b0;
    logic       ss_prev2 = 1'b1;
    logic [7:0] rxq2[$];

    always @(negedge clk) begin
        if (rst) begin
            ss_run2 = 0; sclk_prev2 = 1'b0; ss_prev2 = 1'b1;
        end else begin
            if (spi_clk2 && !sclk_prev2) begin
                rises2++;
                rise_gap2 = cyc - last_rise_cyc2;
                last_rise_cyc2 = cyc;
            end
            if (!spi_ss2) ss_run2++;
            else begin
                if (!ss_prev2) last_ss_run2 = ss_run2;
                ss_run2 = 0;
            end
            if (rx_valid2) rxq2.push_back(rx_data2);
            sclk_prev2 = spi_clk2;
            ss_prev2   = spi_ss2;
        end
    end

    task automatic send(input logic [7:0] d, input logic last, input logic keep);
        int n = 0;
        tx_data = d; tx_last = last; tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout: tx_ready=%0b after %0d cycles, want 1", tx_ready, n);
        end
        @(posedge clk); #1;
        if (!keep) tx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send2(input logic [7:0] d, input logic last);
        int n = 0;
        tx_data2 = d; tx_last2 = last; tx_valid2 = 1'b1;
        while (!tx_ready2 && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) begin
            tests_run++; tests_failed++;
            $display("FAIL send2_timeout: tx_ready2=%0b after %0d cycles, want 1", tx_ready2, n);
        end
        @(posedge clk); #1;
        tx_valid2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int rx_target);
        int n = 0;
        while ((rxq.size() < rx_target || busy) && n < 4000) begin
            @(negedge clk); n++;
        end
        if (n >= 4000) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_done_timeout: rx count %0d busy %0b, want %0d and 0", rxq.size(), busy, rx_target);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({spi_ss, spi_clk, mosi, tx_ready, rx_valid, busy, rx_data} !== {6'b100000, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_values: ss/clk/mosi/rdy/rxv/busy/rxd=%b, want 10000000000000",
                     {spi_ss, spi_clk, mosi, tx_ready, rx_valid, busy, rx_data});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({tx_ready, busy, spi_ss} !== 3'b101) begin
            tests_failed++;
            $display("FAIL idle_after_reset: rdy/busy/ss=%b, want 101", {tx_ready, busy, spi_ss});
        end
    endtask

    task automatic test_single_loopback();
        int r0 = rises;
        int q0 = rxq.size();
        int s0 = slave_q.size();
        loop = 1'b1;
        send(8'hA5, 1'b1, 1'b0);
        wait_done(q0 + 1);
        tests_run++;
        if (rises - r0 !== 8) begin
            tests_failed++; $display("FAIL single_rises: got %0d, want 8", rises - r0);
        end
        tests_run++;
        if (rxq.size() - q0 !== 1 || rxq[q0] !== 8'hA5) begin
            tests_failed++; $display("FAIL single_rx: count %0d data %h, want 1 a5", rxq.size() - q0, rxq[q0]);
        end
        tests_run++;
        if (last_ss_run !== 36) begin
            tests_failed++; $display("FAIL single_ss_low: got %0d cycles, want 36", last_ss_run);
        end
        tests_run++;
        if (busy_fall_cyc - rxv_cyc !== 4) begin
            tests_failed++; $display("FAIL single_busy_drop: got %0d cycles, want 4", busy_fall_cyc - rxv_cyc);
        end
        tests_run++;
        if (slave_q[s0] !== 8'hA5) begin
            tests_failed++; $display("FAIL single_mosi: got %h, want a5", slave_q[s0]);
        end
    endtask

    task automatic test_two_word();
        int r0 = rises;
        int q0 = rxq.size();
        int s0 = slave_q.size();
        int e0 = ss_rises;
        loop = 1'b1;
        send(8'h12, 1'b0, 1'b1);
        send(8'h34, 1'b1, 1'b0);
        wait_done(q0 + 2);
        tests_run++;
        if (rises - r0 !== 16) begin
            tests_failed++; $display("FAIL two_rises: got %0d, want 16", rises - r0);
        end
        tests_run++;
        if (ss_rises - e0 !== 1 || last_ss_run !== 72) begin
            tests_failed++;
            $display("FAIL two_ss_low: deselects %0d run %0d, want 1 72", ss_rises - e0, last_ss_run);
        end
        tests_run++;
        if (rxq[q0] !== 8'h12 || rxq[q0+1] !== 8'h34) begin
            tests_failed++; $display("FAIL two_rx: got %h %h, want 12 34", rxq[q0], rxq[q0+1]);
        end
        tests_run++;
        if (slave_q[s0] !== 8'h12 || slave_q[s0+1] !== 8'h34) begin
            tests_failed++; $display("FAIL two_slave: got %h %h, want 12 34", slave_q[s0], slave_q[s0+1]);
        end
    endtask

    task automatic test_miso_tied();
        int q0 = rxq.size();
        int s0 = slave_q.size();
        loop = 1'b0;
        miso_fix = 1'b1;
        send(8'h96, 1'b1, 1'b0);
        wait_done(q0 + 1);
        miso_fix = 1'b0;
        send(8'h96, 1'b1, 1'b0);
        wait_done(q0 + 2);
        loop = 1'b1;
        tests_run++;
        if (rxq[q0] !== 8'hFF || rxq[q0+1] !== 8'h00) begin
            tests_failed++; $display("FAIL miso_tied_rx: got %h %h, want ff 00", rxq[q0], rxq[q0+1]);
        end
        tests_run++;
        if (slave_q[s0] !== 8'h96 || slave_q[s0+1] !== 8'h96) begin
            tests_failed++; $display("FAIL miso_tied_mosi: got %h %h, want 96 96", slave_q[s0], slave_q[s0+1]);
        end
    endtask

    task automatic test_next_wait();
        int q0 = rxq.size();
        int bad = 0;
        int n = 0;
        loop = 1'b1;
        send(8'hC3, 1'b0, 1'b0);
        while (rxq.size() < q0 + 1 && n < 2000) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(tx_ready === 1'b1 && spi_ss === 1'b0 && spi_clk === 1'b0 && busy === 1'b1)) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("FAIL next_wait_hold: %0d bad cycles, want 0", bad);
        end
        send(8'h3C, 1'b1, 1'b0);
        wait_done(q0 + 2);
        tests_run++;
        if (rxq[q0] !== 8'hC3 || rxq[q0+1] !== 8'h3C) begin
            tests_failed++; $display("FAIL next_wait_rx: got %h %h, want c3 3c", rxq[q0], rxq[q0+1]);
        end
    endtask

    task automatic test_mid_reset();
        int r0 = rises;
        int q0 = rxq.size();
        int n = 0;
        loop = 1'b1;
        send(8'h77, 1'b1, 1'b0);
        while (rises - r0 < 4 && n < 2000) begin
            @(negedge clk); n++;
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({spi_ss, spi_clk, mosi, tx_ready, rx_valid, busy, rx_data} !== {6'b100000, 8'h00}) begin
            tests_failed++;
            $display("FAIL mid_reset_async: ss/clk/mosi/rdy/rxv/busy/rxd=%b, want 10000000000000",
                     {spi_ss, spi_clk, mosi, tx_ready, rx_valid, busy, rx_data});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (rxq.size() !== q0) begin
            tests_failed++; $display("FAIL mid_reset_no_rx: got %0d pulses, want 0", rxq.size() - q0);
        end
        send(8'h5A, 1'b1, 1'b0);
        wait_done(q0 + 1);
        tests_run++;
        if (rxq[q0] !== 8'h5A) begin
            tests_failed++; $display("FAIL mid_reset_recover: got %h, want 5a", rxq[q0]);
        end
    endtask

    task automatic test_div1();
        int r0 = rises2;
        int q0 = rxq2.size();
        int n = 0;
        send2(8'hFF, 1'b1);
        while ((rxq2.size() < q0 + 1 || busy2) && n < 2000) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (rises2 - r0 !== 8 || rise_gap2 !== 2) begin
            tests_failed++; $display("FAIL div1_clk: rises %0d period %0d, want 8 2", rises2 - r0, rise_gap2);
        end
        tests_run++;
        if (last_ss_run2 !== 18) begin
            tests_failed++; $display("FAIL div1_ss_low: got %0d cycles, want 18", last_ss_run2);
        end
        tests_run++;
        if (rxq2.size() - q0 !== 1 || rxq2[q0] !== 8'hFF) begin
            tests_failed++; $display("FAIL div1_rx: count %0d data %h, want 1 ff", rxq2.size() - q0, rxq2[q0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_loopback();
        test_two_word();
        test_miso_tied();
        test_next_wait();
        test_mid_reset();
        test_div1();
        tests_run++;
        if (overlap !== 0) begin
            tests_failed++; $display("FAIL rx_ready_overlap: got %0d cycles, want 0", overlap);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
